// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmit and receive halves
package uart_pkg;

  localparam int   UART_OVERSAMPLE = 16;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE       = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_bit_timer.sv
// rtl/uart_baud_bit_timer.sv - counts oversampling ticks and flags the end of each serial bit
module uart_baud_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic bit_end
);

  localparam int            CW   = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TERM = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear dominates a coincident tick; the terminal tick wraps the count and ends the bit.
  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == TERM) begin
        cnt_d   = '0;
        bit_end = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_oversampled.sv
// rtl/uart_tx_oversampled.sv - UART transmitter serialising one byte per request as 8N1/8N2
module uart_tx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_tx,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_txd,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int            IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timer_clear;
  logic                 bit_end;

  // Holding the timer cleared while idle makes every start bit count from zero.
  assign timer_clear = (state_q == TX_IDLE);

  uart_baud_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (i_clk_tx),
    .bit_end(bit_end)
  );

  // Next-state, shift register, handshake and the line level for the coming state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (i_tx_start) begin
          state_d = TX_START;
          shift_d = i_tx_data;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = TX_STOP;
            idx_d   = '0;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = TX_IDLE;
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = UART_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= UART_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_txd     = txd_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// tb/tb_uart_tx_oversampled.sv - self-checking bench for uart_tx_oversampled
module tb_uart_tx_oversampled;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_clk_tx;
  logic       i_tx_start;
  logic       i_tx_start2;
  logic [7:0] i_tx_data;
  logic       o_txd, o_tx_busy, o_tx_done;
  logic       o_txd2, o_tx_busy2, o_tx_done2;

  int checks = 0;
  int errors = 0;
  int div = 0;
  bit tick_en = 1'b1;
  bit last_tick = 1'b0;

  typedef struct {
    string      nm;
    int         w;
    logic [7:0] data;
    logic [9:0] line;
    int         nstop;
    int         gate_at;
    int         gate_len;
    int         poke_at;
    logic [7:0] poke_data;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  uart_tx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .i_clk_tx  (i_clk_tx),
    .i_tx_start(i_tx_start),
    .i_tx_data (i_tx_data),
    .o_txd     (o_txd),
    .o_tx_busy (o_tx_busy),
    .o_tx_done (o_tx_done)
  );

  uart_tx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .i_clk_tx  (i_clk_tx),
    .i_tx_start(i_tx_start2),
    .i_tx_data (i_tx_data),
    .o_txd     (o_txd2),
    .o_tx_busy (o_tx_busy2),
    .o_tx_done (o_tx_done2)
  );

  function automatic logic txd_of(input int w);
    return (w == 2) ? o_txd2 : o_txd;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 2) ? o_tx_busy2 : o_tx_busy;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 2) ? o_tx_done2 : o_tx_done;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 2) i_tx_start2 = v;
    else        i_tx_start  = v;
  endtask

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: remember the tick the DUT samples on this edge, then set up the next tick.
  task automatic step();
    last_tick = i_clk_tx;
    @(posedge clk);
    #1;
    div = (div == 3) ? 0 : div + 1;
    i_clk_tx = tick_en && (div == 3);
  endtask

  // Request a frame on an edge that carries a tick so the start bit is a full 64 clk.
  task automatic start_frame(input int w, input logic [7:0] d);
    int n;
    n = 0;
    while (!i_clk_tx && n < 8) begin
      step();
      n++;
    end
    i_tx_data = d;
    set_start(w, 1'b1);
    step();
  endtask

  // Called right after the acceptance edge; walks the frame bit by bit using a tick-count model.
  task automatic check_frame(input string nm, input int w, input logic [9:0] line,
                             input int nstop, input bit hold, input int gate_at,
                             input int gate_len, input int poke_at, input logic [7:0] poke_data);
    int   slot, tcnt, k, slot_len, bad, busy_bad, done_bad, stop_clk, nslots;
    logic exp_bit;
    slot = 0; tcnt = 0; k = 0; slot_len = 0; bad = 0;
    busy_bad = 0; done_bad = 0; stop_clk = 0; nslots = 9 + nstop;
    while (slot < nslots && k < 4000) begin
      exp_bit = (slot < 10) ? line[9-slot] : 1'b1;
      if (txd_of(w) !== exp_bit) bad++;
      if (busy_of(w) !== 1'b1) busy_bad++;
      if (done_of(w) !== 1'b0) done_bad++;
      slot_len++;
      if (k == 0) begin
        if (!hold) set_start(w, 1'b0);
        i_tx_data = ~i_tx_data;
      end
      if (k == gate_at) tick_en = 1'b0;
      if (k == gate_at + gate_len) tick_en = 1'b1;
      if (k == poke_at) begin
        i_tx_data = poke_data;
        set_start(w, 1'b1);
      end
      if (poke_at >= 0 && k == poke_at + 1) set_start(w, 1'b0);
      step();
      k++;
      if (last_tick) begin
        tcnt++;
        if (tcnt == OS) begin
          chk(bad == 0, $sformatf("%s bit%0d level", nm, slot), bad, 0);
          if (slot >= 9) stop_clk += slot_len;
          slot++;
          tcnt = 0;
          bad = 0;
          slot_len = 0;
        end
      end
    end
    chk(slot == nslots, $sformatf("%s frame complete", nm), slot, nslots);
    chk(busy_bad == 0, $sformatf("%s busy during frame", nm), busy_bad, 0);
    chk(done_bad == 0, $sformatf("%s no early done", nm), done_bad, 0);
    chk(stop_clk == 64 * nstop, $sformatf("%s stop width clk", nm), stop_clk, 64 * nstop);
    chk(done_of(w) === 1'b1, $sformatf("%s done pulse", nm), int'(done_of(w)), 1);
    chk(busy_of(w) === 1'b0, $sformatf("%s busy cleared", nm), int'(busy_of(w)), 0);
    chk(txd_of(w) === 1'b1, $sformatf("%s line idle at done", nm), int'(txd_of(w)), 1);
  endtask

  task automatic check_idle(input string nm, input int w, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (txd_of(w) !== 1'b1 || busy_of(w) !== 1'b0 || done_of(w) !== 1'b0) bad++;
    end
    chk(bad == 0, $sformatf("%s idle", nm), bad, 0);
  endtask

  initial begin : main
    int rbad;
    vecs[0] = '{"a5",       1, 8'hA5, 10'b0101001011, 1, -1,   0,  -1, 8'h00};
    vecs[1] = '{"3c_poke",  1, 8'h3C, 10'b0001111001, 1, -1,   0, 200, 8'h99};
    vecs[2] = '{"5a_gate",  1, 8'h5A, 10'b0010110101, 1, 300, 200, -1, 8'h00};
    vecs[3] = '{"81_stop2", 2, 8'h81, 10'b0100000011, 2, -1,   0,  -1, 8'h00};

    reset = 1'b1;
    i_clk_tx = 1'b0;
    i_tx_start = 1'b0;
    i_tx_start2 = 1'b0;
    i_tx_data = 8'h00;
    #1;
    chk(o_txd === 1'b1, "reset txd", int'(o_txd), 1);
    chk(o_tx_busy === 1'b0, "reset busy", int'(o_tx_busy), 0);
    chk(o_tx_done === 1'b0, "reset done", int'(o_tx_done), 0);
    chk(o_txd2 === 1'b1, "reset txd2", int'(o_txd2), 1);
    repeat (3) step();
    reset = 1'b0;
    check_idle("post reset", 1, 20);

    for (int v = 0; v < 4; v++) begin
      start_frame(vecs[v].w, vecs[v].data);
      check_frame(vecs[v].nm, vecs[v].w, vecs[v].line, vecs[v].nstop, 1'b0,
                  vecs[v].gate_at, vecs[v].gate_len, vecs[v].poke_at, vecs[v].poke_data);
      check_idle(vecs[v].nm, vecs[v].w, 150);
    end

    // Back-to-back: start held high, data switched to 0xFF on the done pulse.
    start_frame(1, 8'h00);
    check_frame("b2b_00", 1, 10'b0000000001, 1, 1'b1, -1, 0, -1, 8'h00);
    i_tx_data = 8'hFF;
    step();
    chk(o_txd === 1'b0, "b2b start 1clk after done", int'(o_txd), 0);
    chk(o_tx_done === 1'b0, "b2b done one clk", int'(o_tx_done), 0);
    check_frame("b2b_ff", 1, 10'b0111111111, 1, 1'b1, -1, 0, -1, 8'h00);
    i_tx_start = 1'b0;
    check_idle("b2b", 1, 150);

    // Reset during data bit 3 of 0x55, then a clean 0x0F frame.
    start_frame(1, 8'h55);
    i_tx_start = 1'b0;
    repeat (266) step();
    chk(o_txd === 1'b0, "pre-reset bit3 level", int'(o_txd), 0);
    chk(o_tx_busy === 1'b1, "pre-reset busy", int'(o_tx_busy), 1);
    #1 reset = 1'b1;
    #1;
    chk(o_txd === 1'b1, "async reset txd", int'(o_txd), 1);
    chk(o_tx_busy === 1'b0, "async reset busy", int'(o_tx_busy), 0);
    chk(o_tx_done === 1'b0, "async reset done", int'(o_tx_done), 0);
    rbad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_txd !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) rbad++;
    end
    chk(rbad == 0, "held reset", rbad, 0);
    reset = 1'b0;
    check_idle("after reset release", 1, 100);
    start_frame(1, 8'h0F);
    check_frame("0f_after_reset", 1, 10'b0111100001, 1, 1'b0, -1, 0, -1, 8'h00);
    check_idle("0f_after_reset", 1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_oversampled.md
Name: uart_tx_oversampled

Overview:
- UART transmitter: serialises one byte per request onto o_txd as an 8N1 (or 8N2) frame.
- Bit timing uses the shared oversampling baud-tick pulse, the same 16x tick that drives the companion receiver.
- Sits between the CPU/UART register interface and the serial pin; it is the transmit half of the UART.
- Provides a simple start/busy/done handshake toward the bus side.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- OVERSAMPLE, 16, baud ticks per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- i_clk_tx  input  1  baud tick; one-clk-wide pulse at OVERSAMPLE x baud rate.
- i_tx_start  input  1  request to send i_tx_data; level-sampled each clk.
- i_tx_data  input  DATA_BITS  byte to send; captured on acceptance.
- o_txd  output  1  serial line; idles high.
- o_tx_busy  output  1  high from acceptance until the frame completes.
- o_tx_done  output  1  one-clk pulse when the last stop bit finishes.

Behaviour:
- Reset (async, active-high): state=IDLE, o_txd=1, o_tx_busy=0, o_tx_done=0, shift register=0, tick counter=0, bit index=0. Outputs take these values immediately on reset assertion, including mid-frame; the partial frame is abandoned and no done pulse is issued.
- States: IDLE, START, DATA, STOP. o_txd is registered: IDLE=1, START=0, DATA=shift_reg[0], STOP=1.
- Acceptance:
  - In IDLE with i_tx_start=1 at a clk edge, latch i_tx_data, go to START and set o_tx_busy=1 on that edge.
  - o_txd falls in the same edge, i.e. one clk after start is sampled; acceptance does not wait for a tick.
  - i_tx_start outside IDLE is ignored: no queuing, no data overwrite.
- Bit timing:
  - Tick counter (width clog2(OVERSAMPLE)) clears on entering each bit and increments only on clk edges where i_clk_tx=1.
  - A bit ends on the edge where i_clk_tx=1 and counter==OVERSAMPLE-1; the counter wraps to 0 there.
  - Each bit therefore lasts exactly OVERSAMPLE ticks after its first tick. The start bit may be up to one tick period longer, because acceptance is asynchronous to the tick.
- Transitions at bit end:
  - START->DATA, with bit index=0.
  - In DATA: shift the register right by 1 and increment the index. On index==DATA_BITS-1, go to STOP.
  - In STOP: a stop-bit counter counts STOP_BITS bit periods, then the block returns to IDLE.
- Completion:
  - On the STOP->IDLE edge: o_tx_busy=0 and o_tx_done=1 for exactly one clk.
  - A start request sampled in the cycle where o_tx_done=1 (state already IDLE) is accepted, giving back-to-back frames with the line high for exactly STOP_BITS periods.
- i_tx_data changes after acceptance have no effect on the frame in flight.
- Counters never exceed their terminal values; no arithmetic overflow paths exist.

Decomposition:
- Shared package uart_pkg, also used by the receiver:
  - state enum/localparams TX_IDLE, TX_START, TX_DATA, TX_STOP;
  - default OVERSAMPLE=16 and DATA_BITS=8;
  - line idle level constant UART_IDLE=1'b1.
- One sub-module, uart_baud_bit_timer:
  - counts i_clk_tx ticks up to OVERSAMPLE-1;
  - outputs a one-clk bit_end pulse;
  - inputs: clear, tick.
- The FSM, shift register and handshake stay in the top module.

Test Plan:
- Basic frame: tick every 4 clk, send 0xA5 → after start bit, o_txd carries 1,0,1,0,0,1,0,1 (LSB first), each bit 64 clk wide. Stop high for 64 clk, then one o_tx_done pulse. o_tx_busy is high about 640 clk.
- Back-to-back: hold i_tx_start=1 with 0x00 then 0xFF, switching data on the done pulse → second start bit begins 1 clk after done; exactly 64 clk of stop-high between frames; payload bits 0x00 then 0xFF.
- Ignore while busy: start 0x3C, pulse i_tx_start with 0x99 mid-frame → frame still 0x3C; only one o_tx_done; busy profile unchanged.
- STOP_BITS=2: send 0x81 → stop-high lasts 128 clk before o_tx_done; frame length 11 bit periods.
- Reset mid-frame: assert reset during DATA bit 3 of 0x55 → o_txd=1 and o_tx_busy=0 immediately, no o_tx_done. After release a new 0x0F request sends a clean full frame.
- Tick gating: hold i_clk_tx=0 for 200 clk during DATA → o_txd is frozen at the current bit level, state does not advance, and the frame resumes correctly when ticks return.
